// File: rtl/vx_dispatch_gather.sv
// vx_dispatch_gather: receive-side endpoint of the transposed dispatch bus.
// Each of the ISSUE_WIDTH channels lands in a 2-entry FIFO. A round-robin
// arbiter over the FIFO heads feeds one registered output stage, which tags
// each beat with the issue slice it came from.
// Optional: define VX_DISPATCH_GATHER_PERF_EN to add the perf_stalls and
// perf_conflicts saturating counters.
module vx_dispatch_gather #(
  parameter int unsigned ISSUE_WIDTH = 4,
  parameter int unsigned DATAW       = 128,
  parameter int unsigned ISW_W       = 2,
  parameter int unsigned PERF_W      = 44
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ISSUE_WIDTH-1:0]       in_valid,
  input  logic [ISSUE_WIDTH*DATAW-1:0] in_data,
  output logic [ISSUE_WIDTH-1:0]       in_ready,
  output logic                         out_valid,
  output logic [DATAW-1:0]             out_data,
  output logic [ISW_W-1:0]             out_isw,
  input  logic                         out_ready
`ifdef VX_DISPATCH_GATHER_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_stalls,
  output logic [PERF_W-1:0]            perf_conflicts
`endif
);

  // Per-channel FIFO: slot0_q is always the head
  logic [1:0]       cnt_q   [ISSUE_WIDTH];
  logic [DATAW-1:0] slot0_q [ISSUE_WIDTH];
  logic [DATAW-1:0] slot1_q [ISSUE_WIDTH];

  // Holds in_ready low for the first cycle after reset release
  logic ready_en_q;

  logic [ISW_W-1:0] rr_q;
  logic             out_valid_q;
  logic [DATAW-1:0] out_data_q;
  logic [ISW_W-1:0] out_isw_q;

  logic [ISSUE_WIDTH-1:0] req;
  logic [ISSUE_WIDTH-1:0] push;
  logic [ISSUE_WIDTH-1:0] pop;
  logic [DATAW-1:0]       din [ISSUE_WIDTH];
  logic                   grant_found;
  logic [ISW_W-1:0]       grant_idx;
  logic                   grant_take;
  logic                   multi_req;
  logic [ISW_W-1:0]       rr_nxt;
  int unsigned            cand;

  // Handshake decode; ready comes only from registered state
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      din[i]      = in_data[i*DATAW +: DATAW];
      req[i]      = (cnt_q[i] != 2'd0);
      in_ready[i] = ready_en_q && (cnt_q[i] != 2'd2);
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Round-robin search: first requester at or after rr_q, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= ISSUE_WIDTH) cand = cand - ISSUE_WIDTH;
      if (!grant_found && req[cand[ISW_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ISW_W-1:0];
      end
    end
  end

  // Grant is only taken when the output stage is free or draining
  always_comb begin
    grant_take = grant_found && (!out_valid_q || out_ready);
    multi_req  = |(req & (req - 1'b1));
    rr_nxt     = (32'(grant_idx) == ISSUE_WIDTH - 1) ? '0 : grant_idx + 1'b1;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      pop[i] = grant_take && (grant_idx == ISW_W'(i));
    end
  end

  // FIFO storage; push+pop only happens at count 1, so the new beat becomes head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        cnt_q[i]   <= 2'd0;
        slot0_q[i] <= '0;
        slot1_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        case ({push[i], pop[i]})
          2'b10: begin
            if (cnt_q[i] == 2'd0) slot0_q[i] <= din[i];
            else                  slot1_q[i] <= din[i];
            cnt_q[i] <= cnt_q[i] + 2'd1;
          end
          2'b01: begin
            slot0_q[i] <= slot1_q[i];
            cnt_q[i]   <= cnt_q[i] - 2'd1;
          end
          2'b11: slot0_q[i] <= din[i];
          default: ;
        endcase
      end
    end
  end

  // Output register, round-robin pointer and ready enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q  <= 1'b0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_isw_q   <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (grant_take) begin
        rr_q        <= rr_nxt;
        out_valid_q <= 1'b1;
        out_data_q  <= slot0_q[grant_idx];
        out_isw_q   <= grant_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_isw   = (ISSUE_WIDTH == 1) ? '0 : out_isw_q;

`ifdef VX_DISPATCH_GATHER_PERF_EN
  logic [PERF_W-1:0] stalls_q;
  logic [PERF_W-1:0] conflicts_q;

  // Saturating event counters, visible one cycle after the event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stalls_q    <= '0;
      conflicts_q <= '0;
    end else begin
      if (out_valid_q && !out_ready && (stalls_q != '1)) stalls_q <= stalls_q + 1'b1;
      if (grant_take && multi_req && (conflicts_q != '1)) conflicts_q <= conflicts_q + 1'b1;
    end
  end

  assign perf_stalls    = stalls_q;
  assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_vx_dispatch_gather.sv
// Self-checking bench for vx_dispatch_gather: queue-based reference model,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vx_dispatch_gather;
  localparam int W  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int PW = 44;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    in_valid;
  logic [W*DW-1:0] in_data;
  logic [W-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_isw;
  logic            out_ready;
`ifdef VX_DISPATCH_GATHER_PERF_EN
  logic [PW-1:0]   perf_stalls;
  logic [PW-1:0]   perf_conflicts;
`endif

  always #5 clk = ~clk;

  vx_dispatch_gather #(
    .ISSUE_WIDTH (W),
    .DATAW       (DW),
    .ISW_W       (IW),
    .PERF_W      (PW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_isw        (out_isw),
    .out_ready      (out_ready)
`ifdef VX_DISPATCH_GATHER_PERF_EN
    ,
    .perf_stalls    (perf_stalls),
    .perf_conflicts (perf_conflicts)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one queue per channel, capacity 2
  logic [DW-1:0] mq [W][$];
  int            m_rr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_isw;
  bit            m_en;
  longint        m_stalls;
  longint        m_conf;

  function automatic bit model_ready(input int i);
    return m_en && (mq[i].size() < 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < W; i++) mq[i].delete();
    m_rr = 0; m_valid = 0; m_data = '0; m_isw = '0; m_en = 0;
    m_stalls = 0; m_conf = 0;
  endtask

  task automatic model_step();
    bit rdy [W];
    int nreq;
    int g;
    int c;
    bit take;
    if (!reset) begin
      model_clear();
      return;
    end
    nreq = 0;
    g    = -1;
    for (int i = 0; i < W; i++) begin
      rdy[i] = model_ready(i);
      if (mq[i].size() > 0) nreq++;
    end
    for (int k = 0; k < W; k++) begin
      c = (m_rr + k) % W;
      if (g < 0 && mq[c].size() > 0) g = c;
    end
    take = (g >= 0) && (!m_valid || out_ready);
    if (m_valid && !out_ready) m_stalls++;
    if (take && nreq > 1) m_conf++;
    if (take) begin
      m_data  = mq[g].pop_front();
      m_isw   = IW'(g);
      m_valid = 1;
      m_rr    = (g + 1) % W;
    end else if (out_ready) begin
      m_valid = 0;
    end
    for (int i = 0; i < W; i++)
      if (in_valid[i] && rdy[i]) mq[i].push_back(in_data[i*DW +: DW]);
    m_en = 1;
  endtask

  task automatic compare();
    logic [W-1:0] er;
    for (int i = 0; i < W; i++) er[i] = model_ready(i);
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_isw", out_isw, m_isw);
`ifdef VX_DISPATCH_GATHER_PERF_EN
    check("perf_stalls", perf_stalls, m_stalls);
    check("perf_conflicts", perf_conflicts, m_conf);
`endif
  endtask

  // One clock: model advances on the edge, outputs checked on the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = '0;
    model_clear();
    #1;
    compare();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    check("rel_in_ready", in_ready, 4'b1111);
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
  int acc;
  bit f;

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    compare();
    check("init_in_ready", in_ready, 4'b0000);
    reset = 1'b1;
    tick();
    check("init_rel_in_ready", in_ready, 4'b1111);

    // Single channel, back-to-back
    in_valid = 4'b0100;
    in_data[2*DW +: DW] = 32'hA;
    tick();
    check("single_first_invalid", out_valid, 0);
    in_data[2*DW +: DW] = 32'hB;
    tick();
    check("single_a", out_data, 32'hA);
    check("single_a_isw", out_isw, 2);
    in_data[2*DW +: DW] = 32'hC;
    tick();
    check("single_b", out_data, 32'hB);
    in_valid = '0;
    tick();
    check("single_c", out_data, 32'hC);
    check("single_c_isw", out_isw, 2);
    tick();
    check("single_drain", out_valid, 0);

    // Round-robin with all channels requesting
    do_reset();
    in_valid = 4'b1111;
    for (int i = 0; i < W; i++) in_data[i*DW +: DW] = 32'h100 + i;
    tick();
    for (int j = 0; j < 6; j++) begin
      tick();
      check("rr_valid", out_valid, 1);
      check("rr_isw", out_isw, rr_exp[j]);
    end
    in_valid = '0;
    repeat (8) tick();

    // Backpressure on channel 1
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    acc = 0;
    in_data[DW +: DW] = 32'd1;
    for (int c = 0; c < 8; c++) begin
      f = model_ready(1);
      tick();
      if (f) begin
        acc++;
        in_data[DW +: DW] = acc + 1;
      end
      if (c >= 1) check("bp_frozen", out_data, 32'd1);
    end
    check("bp_accepted", acc, 3);
    check("bp_in_ready1", in_ready[1], 0);
    in_valid  = '0;
    out_ready = 1'b1;
    tick();
    check("bp_second", out_data, 32'd2);
    tick();
    check("bp_third", out_data, 32'd3);
    tick();
    check("bp_drained", out_valid, 0);

    // Push and pop in the same cycle on channel 0
    do_reset();
    in_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      in_data[0 +: DW] = 32'h200 + c;
      tick();
      if (c >= 1) begin
        check("pp_in_ready", in_ready, 4'b1111);
        check("pp_out_valid", out_valid, 1);
      end
    end
    in_valid = '0;
    tick();

    // Mid-stream reset with three beats held
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0111;
    tick();
    in_valid = '0;
    tick();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("no_stale", out_valid, 0);
    end

`ifdef VX_DISPATCH_GATHER_PERF_EN
    do_reset();
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    tick();
    in_valid = '0;
    repeat (6) tick();
    check("perf_stalls_5", perf_stalls, 5);
    do_reset();
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    repeat (5) tick();
    check("perf_conflicts_4", perf_conflicts, 4);
    in_valid = '0;
    repeat (6) tick();
`endif

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_valid  = W'($urandom);
      for (int i = 0; i < W; i++) in_data[i*DW +: DW] = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) do_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vx_dispatch_gather.md
Name: vx_dispatch_gather

Overview:
- Receive-side endpoint of the transposed dispatch bus: one instance per execution unit.
- Collects the ISSUE_WIDTH dispatch channels that all issue slices drive toward that unit and merges them into a single ordered stream for the unit's execute pipeline.
- Buffers each channel in a 2-entry elastic FIFO, arbitrates round-robin and registers the output, tagging each beat with the originating issue-slice index.

Parameters:
- ISSUE_WIDTH, 4, number of dispatch channels (issue slices) feeding this unit, >=1.
- DATAW, 128, width of one dispatch payload in bits.
- ISW_W, 2, width of the issue-slice tag; equals max(1, clog2(ISSUE_WIDTH)).
- PERF_W, 44, width of the performance counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  ISSUE_WIDTH  per-channel dispatch valid.
- in_data  input  ISSUE_WIDTH*DATAW  per-channel payload; channel i occupies bits [i*DATAW +: DATAW].
- in_ready  output  ISSUE_WIDTH  per-channel ready.
- out_valid  output  1  merged stream valid (registered).
- out_data  output  DATAW  merged payload (registered).
- out_isw  output  ISW_W  issue-slice index of out_data (registered).
- out_ready  input  1  downstream ready.

Behaviour:
- Reset: while reset is low, all state clears asynchronously:
  - FIFOs empty, round-robin pointer = 0;
  - out_valid = 0, out_data = 0, out_isw = 0;
  - in_ready forced to all-0.
  - After reset rises, in_ready = all-1 from the next cycle.
- Input handshake:
  - Channel i fires when in_valid[i] && in_ready[i].
  - in_ready[i] = (fifo_count[i] < 2), taken from registered count only.
  - No combinational path from out_ready or any in_valid to in_ready.
  - A full FIFO refuses input even if it pops the same cycle.
- FIFO: 2 entries per channel, count 0..2.
  - Push and pop in the same cycle when count == 1 keeps count = 1.
  - Order is preserved within a channel.
- Arbitration (combinational on FIFO heads):
  - Request vector = FIFOs with count > 0.
  - Grant goes to the first requester at index >= rr_ptr, wrapping modulo ISSUE_WIDTH.
  - Grant is taken only when the output register can load: !out_valid || out_ready.
  - On grant of channel g: pop FIFO g, then rr_ptr <= (g+1) mod ISSUE_WIDTH.
  - With no grant, rr_ptr holds.
- Output register:
  - Loads {data, isw=g} on grant and sets out_valid = 1.
  - If out_ready and no grant, out_valid <= 0 and out_data holds its last value.
  - While out_valid && !out_ready, out_data and out_isw stay stable.
- Latency and throughput:
  - Input fire at edge E0 -> out_valid at E1 at the earliest.
  - Sustained throughput is 1 beat/cycle total.
  - Each channel can sustain 1 beat/cycle only when it is the sole requester.
- Fairness: with all channels continuously requesting, grants rotate 0,1,..,ISSUE_WIDTH-1,0 with no channel starved.
- ISSUE_WIDTH == 1: no arbitration, out_isw tied to 0, still 2-entry FIFO plus output register.
- Reset asserted mid-stream: all buffered beats are discarded; nothing is emitted after reset releases until new input arrives.

Optional Feature:
- Macro: VX_DISPATCH_GATHER_PERF_EN.
- With the macro defined, two output ports are added:
  - perf_stalls (output, PERF_W): counts cycles with out_valid && !out_ready.
  - perf_conflicts (output, PERF_W): counts cycles where more than one FIFO requests while a grant is taken.
- Both counters reset to 0, saturate at all-ones and update one cycle after the event.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive reset low mid-traffic with 3 beats buffered -> out_valid=0 and in_ready=4'b0000 immediately; after release in_ready=4'b1111 next cycle and no stale beat appears.
- Single channel: ISSUE_WIDTH=4, channel 2 sends 0xA,0xB,0xC back-to-back with out_ready=1 -> out_data 0xA,0xB,0xC on consecutive cycles starting one edge after the first fire, out_isw=2 each.
- Round-robin: all 4 channels valid continuously, rr_ptr=0, out_ready=1 -> out_isw sequence 0,1,2,3,0,1.
- Backpressure: out_ready=0 for 6 cycles with channel 1 sending -> out_data frozen; channel 1 accepts exactly 2 more beats, then in_ready[1]=0; after out_ready=1 all 3 beats emerge in order.
- Push/pop same cycle: channel 0 FIFO at count 1 with push plus grant -> count stays 1 and in_ready[0] stays 1.
- Perf (macro on): 5 cycles of out_valid=1, out_ready=0 -> perf_stalls=5; two channels colliding for 4 grants -> perf_conflicts=4.
